digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Multi-cycle, parametrised adder that sums two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a registered carry flop between digits. It extends the team's single-bit full-adder cell to word-wide operands with a start/done handshake, carry-out and signed-overflow flags, and optional subtraction. It sits in the datapath wherever area matters more than single-cycle latency.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of DIGIT
- DIGIT, 4, bits added per cycle; NDIG = WIDTH/DIGIT digit cycles per operation
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- x  in  WIDTH  operand A, captured at the accepted start edge
- y  in  WIDTH  operand B, captured at the accepted start edge
- c_in  in  1  carry-in, captured at the accepted start edge
- sub  in  1  subtract select, captured at the accepted start edge (present only with SUB_EN)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse: result registers just updated
- s_out  out  WIDTH  sum, held until the next completion
- c_out  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into bit WIDTH-1 XOR c_out

## Operation
- One clock (clk); reset is asynchronous and active-low (rst_n).
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start=1: capture x, y, c_in into operand registers and the carry flop; clear digit counter; → RUN. IDLE + start=0: stay. DONE + start=0: → IDLE.
- RUN, each cycle: add the low DIGIT bits of both operand shift registers plus the carry flop; store the carry out in the carry flop; shift operands right by DIGIT; shift the digit sum into the top of the internal sum register; increment the counter.
- On the last digit (counter = NDIG-1): load s_out from the completed sum, c_out from the final carry, ovf from carry-into-MSB XOR final carry; → DONE.
- start during RUN is ignored; there is no queueing.
- Arithmetic is modulo 2^WIDTH; c_out is the unsigned carry; ovf is meaningful for two's-complement operands.
- NDIG = 1 is legal: RUN lasts exactly one cycle.

## Timing
- Reset values: busy=0, done=0, s_out=0, c_out=0, ovf=0; internal registers are 0.
- Start accepted at edge E0. Digits are processed at edges E1…E_NDIG. busy is high from E0 to E_NDIG. done, s_out, c_out and ovf update at E_NDIG. done falls at E_NDIG+1.
- Latency: NDIG cycles from the accepted start edge to done.
- Back-to-back: start held high during DONE is accepted, so throughput is one result every NDIG+1 cycles.
- s_out, c_out and ovf remain stable from completion until the next completion; they do not change during RUN.
- rst_n asserted mid-operation aborts the operation asynchronously: all outputs go to their reset values and no done is produced for the aborted request.

## Configuration
- SUB_EN defined: the sub port exists. With sub=1 at capture, y is stored bitwise-inverted, so the result is x + ~y + c_in. c_in=1 gives x−y; c_in=0 gives x−y−1. c_out=1 means no borrow. ovf uses the same rule.
- SUB_EN undefined: no sub port; the block adds only.

## Test plan
- WIDTH=16, DIGIT=4; x=0x1234, y=0x4321, c_in=0 → done 4 cycles after the start edge; s_out=0x5555, c_out=0, ovf=0; busy high for 4 cycles.
- x=0xFFFF, y=0x0001, c_in=0 → s_out=0x0000, c_out=1, ovf=0 (carry ripples through all 4 digits).
- x=0x7FFF, y=0x0001, c_in=0 → s_out=0x8000, c_out=0, ovf=1. Then x=0x8000, y=0x8000 → s_out=0x0000, c_out=1, ovf=1.
- Pulse start during RUN → ignored, and the first result is unchanged. Hold start high in the DONE cycle with x=0x0001, y=0x0002 → second done exactly 5 cycles after the first with s_out=0x0003. Each done lasts one cycle.
- Drive rst_n low in the 2nd RUN cycle → busy, done and s_out are 0 immediately. After release, no done appears until a new start.
- SUB_EN defined: x=0x0005, y=0x0007, sub=1, c_in=1 → s_out=0xFFFE, c_out=0, ovf=0. x=0x0007, y=0x0005 → s_out=0x0002, c_out=1.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: sums two WIDTH-bit operands DIGIT bits per clock with a registered ripple carry.
// Define SUB_EN to add the sub port (y inverted at capture, giving x + ~y + c_in).
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    if ((DIGIT < 1) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_out_q, s_out_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]       y_eff;
    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_carry;
    logic                   msb_cin;
    logic [WIDTH+DIGIT-1:0] sum_shift;

    always_comb begin
`ifdef SUB_EN
        y_eff = sub ? ~y : y;
`else
        y_eff = y;
`endif
    end

    // One digit of the ripple; carry into the digit's top bit is recovered from its sum bit.
    always_comb begin
        {dig_carry, dig_sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                             + {{DIGIT{1'b0}}, carry_q};
        msb_cin   = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        sum_shift = {dig_sum, sum_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_out_d = s_out_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = x;
                    b_d     = y_eff;
                    carry_d = c_in;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_carry;
                sum_d   = sum_shift[WIDTH+DIGIT-1:DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIG) begin
                    s_out_d = sum_shift[WIDTH+DIGIT-1:DIGIT];
                    c_out_d = dig_carry;
                    ovf_d   = msb_cin ^ dig_carry;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_out_q <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_out_q <= s_out_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s_out = s_out_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4); SUB_EN cases run when defined.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        c_in = 1'b0;
`ifdef SUB_EN
    logic        sub = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [15:0] s_out;
    logic        c_out;
    logic        ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
`ifdef SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s_out (s_out),
        .c_out (c_out),
        .ovf   (ovf)
    );

    // Drive start for one edge; returns at the negedge just after the accepting edge.
    task automatic launch(input logic [15:0] xa, input logic [15:0] ya, input logic ci);
        @(negedge clk);
        x = xa; y = ya; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done, counting cycles and busy-high cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (s_out !== 16'h0000) begin bad++; $display("FAIL reset_s got=%h exp=0000", s_out); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c got=%b exp=0", c_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        launch(16'h1234, 16'h4321, 1'b0);
        total++; if (s_out !== 16'h0000) begin bad++; $display("FAIL basic_hold_s got=%h exp=0000", s_out); end
        wait_done(lat, bcnt);
        total++; if (lat != 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        total++; if (bcnt != 4) begin bad++; $display("FAIL basic_busy got=%0d exp=4", bcnt); end
        total++; if (s_out !== 16'h5555) begin bad++; $display("FAIL basic_s got=%h exp=5555", s_out); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL basic_c got=%b exp=0", c_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        total++; if (s_out !== 16'h5555) begin bad++; $display("FAIL basic_s_held got=%h exp=5555", s_out); end
    endtask

    task automatic test_carry;
        int lat, bcnt;
        launch(16'hFFFF, 16'h0001, 1'b0);
        total++; if (s_out !== 16'h5555) begin bad++; $display("FAIL carry_hold_s got=%h exp=5555", s_out); end
        wait_done(lat, bcnt);
        total++; if (lat != 4) begin bad++; $display("FAIL carry_latency got=%0d exp=4", lat); end
        total++; if (s_out !== 16'h0000) begin bad++; $display("FAIL carry_s got=%h exp=0000", s_out); end
        total++; if (c_out !== 1'b1) begin bad++; $display("FAIL carry_c got=%b exp=1", c_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL carry_ovf got=%b exp=0", ovf); end
        launch(16'h0000, 16'h0000, 1'b1);
        wait_done(lat, bcnt);
        total++; if (s_out !== 16'h0001) begin bad++; $display("FAIL cin_s got=%h exp=0001", s_out); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL cin_c got=%b exp=0", c_out); end
    endtask

    task automatic test_overflow;
        int lat, bcnt;
        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat, bcnt);
        total++; if (s_out !== 16'h8000) begin bad++; $display("FAIL ovf_pos_s got=%h exp=8000", s_out); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL ovf_pos_c got=%b exp=0", c_out); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_pos_ovf got=%b exp=1", ovf); end
        launch(16'h8000, 16'h8000, 1'b0);
        wait_done(lat, bcnt);
        total++; if (s_out !== 16'h0000) begin bad++; $display("FAIL ovf_neg_s got=%h exp=0000", s_out); end
        total++; if (c_out !== 1'b1) begin bad++; $display("FAIL ovf_neg_c got=%b exp=1", c_out); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_neg_ovf got=%b exp=1", ovf); end
    endtask

    task automatic test_ignore_start;
        int lat, bcnt;
        launch(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        x = 16'hAAAA; y = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        lat = lat + 2;
        total++; if (lat != 4) begin bad++; $display("FAIL ign_latency got=%0d exp=4", lat); end
        total++; if (s_out !== 16'h3333) begin bad++; $display("FAIL ign_s got=%h exp=3333", s_out); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ign_no_queue got=done%b/busy%b exp=0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        launch(16'h0100, 16'h0200, 1'b0);
        wait_done(lat, bcnt);
        total++; if (s_out !== 16'h0300) begin bad++; $display("FAIL b2b_first_s got=%h exp=0300", s_out); end
        x = 16'h0001; y = 16'h0002; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_done(lat, bcnt);
        lat = lat + 1;
        total++; if (lat != 5) begin bad++; $display("FAIL b2b_spacing got=%0d exp=5", lat); end
        total++; if (s_out !== 16'h0003) begin bad++; $display("FAIL b2b_second_s got=%h exp=0003", s_out); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done2_pulse got=%b exp=0", done); end
    endtask

    task automatic test_abort;
        int lat, bcnt;
        launch(16'h0F0F, 16'h0101, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        total++; if (s_out !== 16'h0000) begin bad++; $display("FAIL abort_s got=%h exp=0000", s_out); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(lat, bcnt);
        total++; if (lat != 20 || bcnt != 0) begin
            bad++; $display("FAIL abort_no_done got=lat%0d/busy%0d exp=20/0", lat, bcnt);
        end
        launch(16'h0002, 16'h0003, 1'b0);
        wait_done(lat, bcnt);
        total++; if (lat != 4 || s_out !== 16'h0005) begin
            bad++; $display("FAIL abort_recover got=lat%0d/s%h exp=4/0005", lat, s_out);
        end
    endtask

`ifdef SUB_EN
    task automatic test_subtract;
        int lat, bcnt;
        sub = 1'b1;
        launch(16'h0005, 16'h0007, 1'b1);
        sub = 1'b0;
        wait_done(lat, bcnt);
        total++; if (s_out !== 16'hFFFE) begin bad++; $display("FAIL sub_neg_s got=%h exp=FFFE", s_out); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL sub_neg_c got=%b exp=0", c_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sub_neg_ovf got=%b exp=0", ovf); end
        sub = 1'b1;
        launch(16'h0007, 16'h0005, 1'b1);
        sub = 1'b0;
        wait_done(lat, bcnt);
        total++; if (s_out !== 16'h0002) begin bad++; $display("FAIL sub_pos_s got=%h exp=0002", s_out); end
        total++; if (c_out !== 1'b1) begin bad++; $display("FAIL sub_pos_c got=%b exp=1", c_out); end
    endtask
`endif

    initial begin
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_basic;
        test_carry;
        test_overflow;
        test_ignore_start;
        test_back_to_back;
        test_abort;
`ifdef SUB_EN
        test_subtract;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
